// File: rtl/legv8_defs_pkg.sv
// rtl/legv8_defs_pkg.sv - shared LEGv8 pipeline constants and types
package legv8_defs;

    localparam int DATA_WIDTH_DEF = 64;

    // X31 reads as zero in operand positions, so it can never carry a load result.
    localparam logic [4:0] XZR = 5'd31;

    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       uncond;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/idex_stage_hazard_detect.sv
// rtl/idex_stage_hazard_detect.sv - combinational load-use hazard detection
module hazard_detect
    import legv8_defs::*;
(
    input  logic       idex_valid_i,
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_rd_i,
    input  logic [4:0] ifid_rn_i,
    input  logic [4:0] ifid_rm_i,
    input  logic       uses_rm_i,
    input  logic       ex_flush_i,
    output logic       stall_o,
    output logic       pc_write_o,
    output logic       ifid_write_o
);

    logic rn_match;
    logic rm_match;

    assign rn_match = (idex_rd_i == ifid_rn_i);
    assign rm_match = uses_rm_i && (idex_rd_i == ifid_rm_i);

    // A taken branch squashes the dependent instruction, so it must not also freeze fetch.
    assign stall_o = idex_valid_i && idex_mem_read_i && (idex_rd_i != XZR)
                     && (rn_match || rm_match) && !ex_flush_i;

    assign pc_write_o   = !stall_o;
    assign ifid_write_o = !stall_o;

endmodule

// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with bubble insertion and event counters
module idex_stage
    import legv8_defs::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] ID_PC,
    input  logic [DATA_WIDTH-1:0] ID_ReadData1,
    input  logic [DATA_WIDTH-1:0] ID_ReadData2,
    input  logic [DATA_WIDTH-1:0] ID_SignExtImm,
    input  logic [4:0]            IFID_RegisterRn,
    input  logic [4:0]            IFID_RegisterRm,
    input  logic [4:0]            IFID_RegisterRd,
    input  logic                  ID_UsesRm,
    input  logic                  ID_RegWrite,
    input  logic                  ID_MemRead,
    input  logic                  ID_MemWrite,
    input  logic                  ID_MemToReg,
    input  logic                  ID_ALUSrc,
    input  logic                  ID_Branch,
    input  logic                  ID_Uncond,
    input  logic [1:0]            ID_ALUOp,
    input  logic                  EX_Flush,
    output logic [DATA_WIDTH-1:0] IDEX_PC,
    output logic [DATA_WIDTH-1:0] IDEX_ReadData1,
    output logic [DATA_WIDTH-1:0] IDEX_ReadData2,
    output logic [DATA_WIDTH-1:0] IDEX_SignExtImm,
    output logic [4:0]            IDEX_RegisterRn,
    output logic [4:0]            IDEX_RegisterRm,
    output logic [4:0]            IDEX_RegisterRd,
    output logic                  IDEX_RegWrite,
    output logic                  IDEX_MemRead,
    output logic                  IDEX_MemWrite,
    output logic                  IDEX_MemToReg,
    output logic                  IDEX_ALUSrc,
    output logic                  IDEX_Branch,
    output logic                  IDEX_Uncond,
    output logic [1:0]            IDEX_ALUOp,
    output logic                  IDEX_Valid,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  Stall,
    output logic [CNT_WIDTH-1:0]  StallCount,
    output logic [CNT_WIDTH-1:0]  FlushCount
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]            rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
    ctrl_t                 ctrl_q, ctrl_d, id_ctrl;
    logic                  valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic                  stall;
    logic                  bubble;

    hazard_detect u_hazard (
        .idex_valid_i    (valid_q),
        .idex_mem_read_i (ctrl_q.mem_read),
        .idex_rd_i       (rd_q),
        .ifid_rn_i       (IFID_RegisterRn),
        .ifid_rm_i       (IFID_RegisterRm),
        .uses_rm_i       (ID_UsesRm),
        .ex_flush_i      (EX_Flush),
        .stall_o         (stall),
        .pc_write_o      (PCWrite),
        .ifid_write_o    (IFIDWrite)
    );

    assign id_ctrl = '{ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
                       ID_ALUSrc, ID_Branch, ID_Uncond, ID_ALUOp};

    always_comb begin
        // Bubbles zero the specifiers too so forwarding can never match a dead slot.
        bubble  = EX_Flush || stall;
        pc_d    = bubble ? '0 : ID_PC;
        rd1_d   = bubble ? '0 : ID_ReadData1;
        rd2_d   = bubble ? '0 : ID_ReadData2;
        imm_d   = bubble ? '0 : ID_SignExtImm;
        rn_d    = bubble ? '0 : IFID_RegisterRn;
        rm_d    = bubble ? '0 : IFID_RegisterRm;
        rd_d    = bubble ? '0 : IFID_RegisterRd;
        ctrl_d  = bubble ? '0 : id_ctrl;
        valid_d = !bubble;

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (EX_Flush && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
        if (stall && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q        <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            rn_q        <= '0;
            rm_q        <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            rn_q        <= rn_d;
            rm_q        <= rm_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign IDEX_PC         = pc_q;
    assign IDEX_ReadData1  = rd1_q;
    assign IDEX_ReadData2  = rd2_q;
    assign IDEX_SignExtImm = imm_q;
    assign IDEX_RegisterRn = rn_q;
    assign IDEX_RegisterRm = rm_q;
    assign IDEX_RegisterRd = rd_q;
    assign IDEX_RegWrite   = ctrl_q.reg_write;
    assign IDEX_MemRead    = ctrl_q.mem_read;
    assign IDEX_MemWrite   = ctrl_q.mem_write;
    assign IDEX_MemToReg   = ctrl_q.mem_to_reg;
    assign IDEX_ALUSrc     = ctrl_q.alu_src;
    assign IDEX_Branch     = ctrl_q.branch;
    assign IDEX_Uncond     = ctrl_q.uncond;
    assign IDEX_ALUOp      = ctrl_q.alu_op;
    assign IDEX_Valid      = valid_q;
    assign Stall           = stall;
    assign StallCount      = stall_cnt_q;
    assign FlushCount      = flush_cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - self-checking bench for idex_stage
module tb_idex_stage;

    logic        CLOCK;
    logic        RESET_N;
    logic [63:0] i_pc, i_rd1, i_rd2, i_imm;
    logic [4:0]  i_rn, i_rm, i_rd;
    logic        i_uses_rm, i_regw, i_memr, i_memw, i_m2r, i_alusrc, i_br, i_unc, i_flush;
    logic [1:0]  i_aluop;

    logic [63:0] o_pc, o_rd1, o_rd2, o_imm;
    logic [4:0]  o_rn, o_rm, o_rd;
    logic        o_regw, o_memr, o_memw, o_m2r, o_alusrc, o_br, o_unc, o_valid;
    logic [1:0]  o_aluop;
    logic        o_pcw, o_ifidw, o_stall;
    logic [15:0] o_scnt, o_fcnt;

    logic [63:0] s_pc, s_rd1, s_rd2, s_imm;
    logic [4:0]  s_rn, s_rm, s_rd;
    logic        s_regw, s_memr, s_memw, s_m2r, s_alusrc, s_br, s_unc, s_valid;
    logic [1:0]  s_aluop;
    logic        s_pcw, s_ifidw, s_stall;
    logic [1:0]  s_scnt, s_fcnt;

    idex_stage #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .ID_PC(i_pc), .ID_ReadData1(i_rd1), .ID_ReadData2(i_rd2), .ID_SignExtImm(i_imm),
        .IFID_RegisterRn(i_rn), .IFID_RegisterRm(i_rm), .IFID_RegisterRd(i_rd),
        .ID_UsesRm(i_uses_rm), .ID_RegWrite(i_regw), .ID_MemRead(i_memr), .ID_MemWrite(i_memw),
        .ID_MemToReg(i_m2r), .ID_ALUSrc(i_alusrc), .ID_Branch(i_br), .ID_Uncond(i_unc),
        .ID_ALUOp(i_aluop), .EX_Flush(i_flush),
        .IDEX_PC(o_pc), .IDEX_ReadData1(o_rd1), .IDEX_ReadData2(o_rd2), .IDEX_SignExtImm(o_imm),
        .IDEX_RegisterRn(o_rn), .IDEX_RegisterRm(o_rm), .IDEX_RegisterRd(o_rd),
        .IDEX_RegWrite(o_regw), .IDEX_MemRead(o_memr), .IDEX_MemWrite(o_memw),
        .IDEX_MemToReg(o_m2r), .IDEX_ALUSrc(o_alusrc), .IDEX_Branch(o_br), .IDEX_Uncond(o_unc),
        .IDEX_ALUOp(o_aluop), .IDEX_Valid(o_valid), .PCWrite(o_pcw), .IFIDWrite(o_ifidw),
        .Stall(o_stall), .StallCount(o_scnt), .FlushCount(o_fcnt)
    );

    idex_stage #(.DATA_WIDTH(64), .CNT_WIDTH(2)) dut_sat (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .ID_PC(i_pc), .ID_ReadData1(i_rd1), .ID_ReadData2(i_rd2), .ID_SignExtImm(i_imm),
        .IFID_RegisterRn(i_rn), .IFID_RegisterRm(i_rm), .IFID_RegisterRd(i_rd),
        .ID_UsesRm(i_uses_rm), .ID_RegWrite(i_regw), .ID_MemRead(i_memr), .ID_MemWrite(i_memw),
        .ID_MemToReg(i_m2r), .ID_ALUSrc(i_alusrc), .ID_Branch(i_br), .ID_Uncond(i_unc),
        .ID_ALUOp(i_aluop), .EX_Flush(i_flush),
        .IDEX_PC(s_pc), .IDEX_ReadData1(s_rd1), .IDEX_ReadData2(s_rd2), .IDEX_SignExtImm(s_imm),
        .IDEX_RegisterRn(s_rn), .IDEX_RegisterRm(s_rm), .IDEX_RegisterRd(s_rd),
        .IDEX_RegWrite(s_regw), .IDEX_MemRead(s_memr), .IDEX_MemWrite(s_memw),
        .IDEX_MemToReg(s_m2r), .IDEX_ALUSrc(s_alusrc), .IDEX_Branch(s_br), .IDEX_Uncond(s_unc),
        .IDEX_ALUOp(s_aluop), .IDEX_Valid(s_valid), .PCWrite(s_pcw), .IFIDWrite(s_ifidw),
        .Stall(s_stall), .StallCount(s_scnt), .FlushCount(s_fcnt)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: what instruction sits in EX, plus event tallies.
    logic [63:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rn, m_rm, m_rd;
    logic [6:0]  m_ctrl;
    logic [1:0]  m_aluop;
    logic        m_valid;
    int          m_sc, m_fc, m_sc2, m_fc2;

    function automatic logic m_stall();
        logic dep;
        dep = (m_rd == i_rn) || (i_uses_rm && (m_rd == i_rm));
        return m_valid && m_ctrl[5] && (m_rd != 5'd31) && dep && !i_flush;
    endfunction

    function automatic logic [280:0] exp_vec();
        return {m_pc, m_rd1, m_rd2, m_imm, m_rn, m_rm, m_rd, m_ctrl, m_aluop, m_valid};
    endfunction

    function automatic logic [280:0] act_vec();
        return {o_pc, o_rd1, o_rd2, o_imm, o_rn, o_rm, o_rd,
                o_regw, o_memr, o_memw, o_m2r, o_alusrc, o_br, o_unc, o_aluop, o_valid};
    endfunction

    task automatic model_reset();
        {m_pc, m_rd1, m_rd2, m_imm} = '0;
        {m_rn, m_rm, m_rd} = '0;
        m_ctrl = '0; m_aluop = '0; m_valid = 1'b0;
        m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    endtask

    task automatic model_bubble();
        {m_pc, m_rd1, m_rd2, m_imm} = '0;
        {m_rn, m_rm, m_rd} = '0;
        m_ctrl = '0; m_aluop = '0; m_valid = 1'b0;
    endtask

    task automatic tick();
        logic s;
        s = m_stall();
        @(posedge CLOCK);
        if (i_flush) begin
            model_bubble();
            if (m_fc < 65535) m_fc++;
            if (m_fc2 < 3) m_fc2++;
        end else if (s) begin
            model_bubble();
            if (m_sc < 65535) m_sc++;
            if (m_sc2 < 3) m_sc2++;
        end else begin
            m_pc = i_pc; m_rd1 = i_rd1; m_rd2 = i_rd2; m_imm = i_imm;
            m_rn = i_rn; m_rm = i_rm; m_rd = i_rd;
            m_ctrl = {i_regw, i_memr, i_memw, i_m2r, i_alusrc, i_br, i_unc};
            m_aluop = i_aluop; m_valid = 1'b1;
        end
        #1;
    endtask

    task automatic set_idle();
        {i_pc, i_rd1, i_rd2, i_imm} = '0;
        {i_rn, i_rm, i_rd} = '0;
        {i_uses_rm, i_regw, i_memr, i_memw, i_m2r, i_alusrc, i_br, i_unc, i_flush} = '0;
        i_aluop = 2'b00;
    endtask

    task automatic set_load(input logic [4:0] rd);
        set_idle();
        i_memr = 1'b1; i_regw = 1'b1; i_m2r = 1'b1; i_alusrc = 1'b1;
        i_rd = rd; i_pc = 64'h400; i_imm = 64'h8;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        set_idle();
        model_reset();
        #2;
        n_assert++;
        if (act_vec() !== '0) begin n_fail++; $display("FAIL reset_regs actual=%h required=0", act_vec()); end
        n_assert++;
        if ({o_scnt, o_fcnt} !== 32'h0) begin n_fail++; $display("FAIL reset_counts actual=%h required=0", {o_scnt, o_fcnt}); end
        n_assert++;
        if ({o_pcw, o_ifidw, o_stall} !== 3'b110) begin n_fail++; $display("FAIL reset_hazard actual=%b required=110", {o_pcw, o_ifidw, o_stall}); end
        @(negedge CLOCK);
        RESET_N = 1'b1;
        #1;
    endtask

    task automatic test_capture();
        set_idle();
        i_rd1 = 64'h1234; i_rn = 5'd3; i_regw = 1'b1; i_rd = 5'd2; i_aluop = 2'b10; i_pc = 64'h100;
        tick();
        n_assert++;
        if (o_rd1 !== 64'h1234 || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL capture_rd1 actual=%h/%b required=1234/1", o_rd1, o_valid);
        end
        n_assert++;
        if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL capture_all actual=%h required=%h", act_vec(), exp_vec()); end
    endtask

    task automatic test_load_use();
        set_load(5'd5);
        tick();
        set_idle();
        i_rn = 5'd5; i_rd = 5'd6; i_regw = 1'b1; i_aluop = 2'b10; i_pc = 64'h404;
        #1;
        n_assert++;
        if ({o_stall, o_pcw, o_ifidw} !== 3'b100) begin n_fail++; $display("FAIL loaduse_stall actual=%b required=100", {o_stall, o_pcw, o_ifidw}); end
        tick();
        n_assert++;
        if (o_valid !== 1'b0 || o_memr !== 1'b0 || o_rd !== 5'd0) begin
            n_fail++; $display("FAIL loaduse_bubble actual=%b%b%h required=0000", o_valid, o_memr, o_rd);
        end
        n_assert++;
        if (o_scnt !== 16'd1) begin n_fail++; $display("FAIL loaduse_count actual=%0d required=1", o_scnt); end
        n_assert++;
        if (o_stall !== 1'b0 || o_pcw !== 1'b1) begin n_fail++; $display("FAIL loaduse_release actual=%b%b required=01", o_stall, o_pcw); end
        tick();
        n_assert++;
        if (o_valid !== 1'b1 || o_rn !== 5'd5 || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL loaduse_capture actual=%h required=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_xzr_and_rm();
        set_load(5'd31);
        tick();
        set_idle(); i_rn = 5'd31; i_rm = 5'd31; i_uses_rm = 1'b1;
        #1;
        n_assert++;
        if (o_stall !== 1'b0) begin n_fail++; $display("FAIL xzr_nostall actual=%b required=0", o_stall); end
        set_load(5'd7);
        tick();
        set_idle(); i_rm = 5'd7; i_uses_rm = 1'b0;
        #1;
        n_assert++;
        if (o_stall !== 1'b0) begin n_fail++; $display("FAIL rm_unused actual=%b required=0", o_stall); end
        i_memw = 1'b1; i_uses_rm = 1'b1;
        #1;
        n_assert++;
        if (o_stall !== 1'b1 || o_ifidw !== 1'b0) begin n_fail++; $display("FAIL store_rt_stall actual=%b%b required=10", o_stall, o_ifidw); end
        tick();
        n_assert++;
        if (o_scnt !== 16'(m_sc) || o_valid !== 1'b0) begin n_fail++; $display("FAIL store_count actual=%0d required=%0d", o_scnt, m_sc); end
    endtask

    task automatic test_flush_vs_stall();
        int sc_before;
        set_load(5'd5);
        tick();
        set_idle(); i_rn = 5'd5; i_regw = 1'b1; i_flush = 1'b1;
        #1;
        n_assert++;
        if ({o_stall, o_pcw} !== 2'b01) begin n_fail++; $display("FAIL flush_nostall actual=%b required=01", {o_stall, o_pcw}); end
        sc_before = m_sc;
        tick();
        n_assert++;
        if (o_valid !== 1'b0 || o_regw !== 1'b0 || o_rn !== 5'd0) begin n_fail++; $display("FAIL flush_bubble actual=%b%b%h required=000", o_valid, o_regw, o_rn); end
        n_assert++;
        if (o_fcnt !== 16'd1) begin n_fail++; $display("FAIL flush_count actual=%0d required=1", o_fcnt); end
        n_assert++;
        if (o_scnt !== 16'(sc_before)) begin n_fail++; $display("FAIL flush_stallcount actual=%0d required=%0d", o_scnt, sc_before); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            set_load(5'd9);
            tick();
            set_idle(); i_rn = 5'd9;
            tick();
        end
        set_idle();
        n_assert++;
        if (s_scnt !== 2'd3) begin n_fail++; $display("FAIL sat_hold actual=%0d required=3", s_scnt); end
        n_assert++;
        if (o_scnt !== 16'(m_sc)) begin n_fail++; $display("FAIL sat_wide actual=%0d required=%0d", o_scnt, m_sc); end
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd3;
            2: return 5'd5;
            3: return 5'd7;
            default: return 5'd31;
        endcase
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            i_pc = {$urandom, $urandom}; i_rd1 = {$urandom, $urandom};
            i_rd2 = {$urandom, $urandom}; i_imm = {$urandom, $urandom};
            i_rn = pick_reg(); i_rm = pick_reg(); i_rd = pick_reg();
            i_uses_rm = 1'($urandom_range(0, 1)); i_regw = 1'($urandom_range(0, 1));
            i_memr = 1'($urandom_range(0, 1)); i_memw = 1'($urandom_range(0, 1));
            i_m2r = 1'($urandom_range(0, 1)); i_alusrc = 1'($urandom_range(0, 1));
            i_br = 1'($urandom_range(0, 1)); i_unc = 1'($urandom_range(0, 1));
            i_aluop = 2'($urandom_range(0, 3));
            i_flush = ($urandom_range(0, 9) == 0);
            #1;
            n_assert++;
            if ({o_stall, o_pcw, o_ifidw} !== {m_stall(), !m_stall(), !m_stall()}) begin
                n_fail++; $display("FAIL rand_hazard cycle=%0d actual=%b required=%b", c, {o_stall, o_pcw, o_ifidw}, {m_stall(), !m_stall(), !m_stall()});
            end
            tick();
            n_assert++;
            if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL rand_regs cycle=%0d actual=%h required=%h", c, act_vec(), exp_vec()); end
            n_assert++;
            if (o_scnt !== 16'(m_sc) || o_fcnt !== 16'(m_fc)) begin
                n_fail++; $display("FAIL rand_counts cycle=%0d actual=%0d/%0d required=%0d/%0d", c, o_scnt, o_fcnt, m_sc, m_fc);
            end
            n_assert++;
            if (s_scnt !== 2'(m_sc2) || s_fcnt !== 2'(m_fc2)) begin
                n_fail++; $display("FAIL rand_satcounts cycle=%0d actual=%0d/%0d required=%0d/%0d", c, s_scnt, s_fcnt, m_sc2, m_fc2);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        set_load(5'd3);
        tick();
        set_idle(); i_rn = 5'd3;
        #1;
        n_assert++;
        if (o_stall !== 1'b1) begin n_fail++; $display("FAIL midrst_setup actual=%b required=1", o_stall); end
        @(negedge CLOCK);
        RESET_N = 1'b0;
        model_reset();
        #1;
        n_assert++;
        if (act_vec() !== '0 || {o_scnt, o_fcnt} !== 32'h0) begin
            n_fail++; $display("FAIL midrst_clear actual=%h/%h required=0", act_vec(), {o_scnt, o_fcnt});
        end
        n_assert++;
        if ({o_stall, o_pcw, o_ifidw} !== 3'b011) begin n_fail++; $display("FAIL midrst_hazard actual=%b required=011", {o_stall, o_pcw, o_ifidw}); end
        @(negedge CLOCK);
        RESET_N = 1'b1;
        i_rd1 = 64'hCAFE; i_rd = 5'd4; i_regw = 1'b1;
        #1;
        tick();
        n_assert++;
        if (act_vec() !== exp_vec() || o_scnt !== 16'd0) begin
            n_fail++; $display("FAIL midrst_resume actual=%h required=%h", act_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_xzr_and_rm();
        test_flush_vs_stall();
        test_saturation();
        set_idle();
        tick();
        tick();
        test_random();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
